// File: rtl/mux4_scan_pkg.sv
// Shared constants and state type for the 4:1 mux scan sequencer.
package mux4_scan_pkg;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_SCAN = 1'b1;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned CH_W   = 2;

  typedef enum logic {
    StIdle = ST_IDLE,
    StScan = ST_SCAN
  } state_e;

endpackage

// File: rtl/mux4_next_ch.sv
// Rotating-priority finder: first set mask bit strictly above cur, wrapping 3->0.
// With cur=3 it yields the lowest set bit. If only cur is set, next=cur and wrap=1.
module mux4_next_ch
  import mux4_scan_pkg::*;
(
  input  logic [CH_W-1:0]   cur,
  input  logic [NUM_CH-1:0] mask,
  output logic [CH_W-1:0]   next,
  output logic              wrap
);

  logic            found;
  logic [CH_W-1:0] idx;

  // Walk cur+1 .. cur+4 (mod 4) and keep the first enabled index.
  always_comb begin
    next  = cur;
    found = 1'b0;
    idx   = cur;
    for (int unsigned i = 1; i <= NUM_CH; i++) begin
      idx = cur + CH_W'(i);
      if (!found && mask[idx]) begin
        next  = idx;
        found = 1'b1;
      end
    end
    wrap = found && (next <= cur);
  end

endmodule

// File: rtl/mux4_scan_ctrl.sv
// Drives mux4x1 select lines, cycling through enabled channels with a
// programmable dwell and flagging per-channel and per-scan completion.
module mux4_scan_ctrl
  import mux4_scan_pkg::*;
#(
  parameter int unsigned DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [NUM_CH-1:0]  mask,
  input  logic [DWELL_W-1:0] dwell,
  output logic               sel1,
  output logic               sel0,
  output logic               valid,
  output logic               ch_done,
  output logic               scan_done
);

  state_e             state_q, state_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [CH_W-1:0]    sel_q, sel_d;

  logic [CH_W-1:0]    find_cur;
  logic [CH_W-1:0]    nxt_ch;
  logic               nxt_wrap;
  logic               active;
  logic               last;

  assign active = en && (mask != '0);

  // On entry search from channel 3 so the finder returns the lowest set bit.
  always_comb begin
    find_cur = (state_q == StScan) ? sel_q : CH_W'(NUM_CH - 1);
  end

  mux4_next_ch u_next_ch (
    .cur  (find_cur),
    .mask (mask),
    .next (nxt_ch),
    .wrap (nxt_wrap)
  );

  // Status outputs; pulses are suppressed in a cycle that aborts the scan.
  always_comb begin
    valid     = (state_q == StScan);
    last      = valid && (cnt_q == '0) && active;
    ch_done   = last;
    scan_done = last && nxt_wrap;
    sel1      = sel_q[1];
    sel0      = sel_q[0];
  end

  // Next-state logic: entry, dwell countdown, channel advance and abort.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    unique case (state_q)
      StIdle: begin
        if (active) begin
          state_d = StScan;
          sel_d   = nxt_ch;
          cnt_d   = dwell;
        end
      end
      StScan: begin
        if (!active) begin
          state_d = StIdle;
          sel_d   = '0;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          sel_d = nxt_ch;
          cnt_d = dwell;
        end else begin
          cnt_d = cnt_q - DWELL_W'(1);
        end
      end
      default: begin
        state_d = StIdle;
        sel_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counter and select registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
    end
  end

endmodule

// File: tb/tb_mux4_scan_ctrl.sv
// Directed, table-driven bench for mux4_scan_ctrl with a behavioural 4:1 mux.
module tb_mux4_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [3:0] mask;
  logic [7:0] dwell;
  logic       sel1, sel0, valid, ch_done, scan_done;

  logic [3:0] mux_in;
  logic       mux_out;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       en;
    logic [3:0] mask;
    logic [7:0] dwell;
    logic [1:0] sel;
    logic       valid;
    logic       ch;
    logic       scan;
  } vec_t;

  vec_t vecs[25];

  mux4_scan_ctrl #(.DWELL_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .mask      (mask),
    .dwell     (dwell),
    .sel1      (sel1),
    .sel0      (sel0),
    .valid     (valid),
    .ch_done   (ch_done),
    .scan_done (scan_done)
  );

  // Stand-in for the combinational mux4x1 fed by the select lines.
  assign mux_out = mux_in[{sel1, sel0}];

  always #5 clk = ~clk;

  function automatic vec_t mk(logic e, logic [3:0] m, logic [7:0] d, logic [1:0] s,
                              logic v, logic c, logic sc);
    vec_t r;
    r.en = e; r.mask = m; r.dwell = d; r.sel = s; r.valid = v; r.ch = c; r.scan = sc;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] exp_out;
    int n;

    // {en, mask, dwell} applied, then {sel, valid, ch_done, scan_done} expected.
    // Full scan, mask=1111 dwell=0, then abort via en on a last cycle.
    vecs[0]  = mk(1, 4'hF, 8'd0, 2'd0, 0, 0, 0);
    vecs[1]  = mk(1, 4'hF, 8'd0, 2'd0, 1, 1, 0);
    vecs[2]  = mk(1, 4'hF, 8'd0, 2'd1, 1, 1, 0);
    vecs[3]  = mk(1, 4'hF, 8'd0, 2'd2, 1, 1, 0);
    vecs[4]  = mk(1, 4'hF, 8'd0, 2'd3, 1, 1, 1);
    vecs[5]  = mk(1, 4'hF, 8'd0, 2'd0, 1, 1, 0);
    vecs[6]  = mk(0, 4'hF, 8'd0, 2'd1, 1, 0, 0);
    vecs[7]  = mk(0, 4'hA, 8'd2, 2'd0, 0, 0, 0);
    // Skip, mask=1010 dwell=2, then abort via mask=0 mid-dwell at sel=01.
    vecs[8]  = mk(1, 4'hA, 8'd2, 2'd0, 0, 0, 0);
    vecs[9]  = mk(1, 4'hA, 8'd2, 2'd1, 1, 0, 0);
    vecs[10] = mk(1, 4'hA, 8'd2, 2'd1, 1, 0, 0);
    vecs[11] = mk(1, 4'hA, 8'd2, 2'd1, 1, 1, 0);
    vecs[12] = mk(1, 4'hA, 8'd2, 2'd3, 1, 0, 0);
    vecs[13] = mk(1, 4'hA, 8'd2, 2'd3, 1, 0, 0);
    vecs[14] = mk(1, 4'hA, 8'd2, 2'd3, 1, 1, 1);
    vecs[15] = mk(1, 4'hA, 8'd2, 2'd1, 1, 0, 0);
    vecs[16] = mk(1, 4'h0, 8'd2, 2'd1, 1, 0, 0);
    vecs[17] = mk(1, 4'h0, 8'd2, 2'd0, 0, 0, 0);
    // Single channel, mask=0100 dwell=1.
    vecs[18] = mk(1, 4'h4, 8'd1, 2'd0, 0, 0, 0);
    vecs[19] = mk(1, 4'h4, 8'd1, 2'd2, 1, 0, 0);
    vecs[20] = mk(1, 4'h4, 8'd1, 2'd2, 1, 1, 1);
    vecs[21] = mk(1, 4'h4, 8'd1, 2'd2, 1, 0, 0);
    vecs[22] = mk(1, 4'h4, 8'd1, 2'd2, 1, 1, 1);
    vecs[23] = mk(0, 4'h4, 8'd1, 2'd2, 1, 0, 0);
    vecs[24] = mk(0, 4'h4, 8'd1, 2'd0, 0, 0, 0);

    rst = 1'b1; en = 1'b0; mask = 4'h0; dwell = 8'd0; mux_in = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {30'd0, sel1, sel0} | {27'd0, valid, ch_done, scan_done, 2'b00},
          32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 25; i++) begin
      en = vecs[i].en; mask = vecs[i].mask; dwell = vecs[i].dwell;
      #1;
      total++;
      if ({sel1, sel0, valid, ch_done, scan_done} !==
          {vecs[i].sel, vecs[i].valid, vecs[i].ch, vecs[i].scan}) begin
        bad++;
        $display("FAIL vec%0d got sel=%b valid=%b ch=%b scan=%b want sel=%b valid=%b ch=%b scan=%b",
                 i, {sel1, sel0}, valid, ch_done, scan_done,
                 vecs[i].sel, vecs[i].valid, vecs[i].ch, vecs[i].scan);
      end
      tick();
    end

    // Asynchronous reset while sel=10, then restart from the lowest channel.
    en = 1'b1; mask = 4'hF; dwell = 8'd0;
    tick(); tick(); tick();
    check("pre_reset_sel", {30'd0, sel1, sel0}, 32'd2);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset", {27'd0, sel1, sel0, valid, ch_done, scan_done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("restart_sel_valid", {29'd0, sel1, sel0, valid}, 32'b001);
    tick();
    check("restart_second_sel", {30'd0, sel1, sel0}, 32'd1);

    // End-to-end with the mux: inputs 1,0,0,1 across one scan.
    en = 1'b0; tick();
    mux_in = 4'b1001; exp_out = 4'b1001;
    en = 1'b1; mask = 4'hF; dwell = 8'd0;
    tick();
    for (int k = 0; k < 4; k++) begin
      #1;
      check($sformatf("mux_out_ch%0d", k), {31'd0, mux_out}, {31'd0, exp_out[k]});
      if (scan_done) check("mux_out_at_scan_done", {31'd0, mux_out}, 32'd1);
      tick();
    end

    // Mid-dwell dwell change takes effect only at the next advance.
    en = 1'b0; tick();
    en = 1'b1; mask = 4'h3; dwell = 8'd2;
    tick();
    dwell = 8'd0;
    tick(); tick();
    #1;
    check("old_dwell_kept", {30'd0, sel1, sel0, 1'b0} | {31'd0, ch_done}, 32'b001);
    tick();
    #1;
    check("new_dwell_used", {30'd0, sel1, sel0, 1'b0} | {31'd0, ch_done}, 32'b011);

    // Maximum dwell: 255 gives a 256-cycle hold.
    en = 1'b0; tick();
    en = 1'b1; mask = 4'h1; dwell = 8'hFF;
    tick();
    n = 0;
    while (n < 300) begin
      n++;
      #1;
      if (ch_done) break;
      tick();
    end
    check("max_dwell_cycles", n, 32'd256);
    check("max_dwell_scan_done", {31'd0, scan_done}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
